// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: register file plus ALU in two stages (read/execute, writeback).
// Register 0 reads as zero. The writeback result is bypassed to the operand reads.
module alu_regfile_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [3:0]        alu_op,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rd,
  input  logic              wr_en,
  output logic              out_valid,
  output logic [WIDTH-1:0]  result,
  output logic              ZF,
  output logic              OF,
  output logic              CF,
  output logic              NF,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;

  logic [WIDTH-1:0]  regs [DEPTH];
  logic [ADDR_W-1:0] w_rd;
  logic              w_wr_en;
  logic              w_commit;
  logic              byp_a;
  logic              byp_b;
  logic [WIDTH-1:0]  a_op;
  logic [WIDTH-1:0]  b_op;
  logic [WIDTH-1:0]  alu_f;
  logic              alu_cf;
  logic              alu_of;
  logic [WIDTH:0]    sum;
  logic [SH_W-1:0]   sh;
  logic              lt_s;

  // Writeback commits only for a valid, enabled, non-zero destination.
  assign w_commit = out_valid && w_wr_en && (w_rd != '0);
  assign byp_a    = w_commit && (w_rd == ra);
  assign byp_b    = w_commit && (w_rd == rb);

  // Operand read with register 0 forced to zero and writeback bypass.
  assign a_op = byp_a ? result : ((ra == '0) ? '0 : regs[ra]);
  assign b_op = byp_b ? result : ((rb == '0) ? '0 : regs[rb]);

  // Debug port sees the array only; in-flight writeback is not visible.
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // ALU: result plus carry/overflow for the current operands.
  always_comb begin
    alu_f  = '0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    sum    = '0;
    sh     = a_op[SH_W-1:0];
    lt_s   = $signed(a_op) < $signed(b_op);
    case (alu_op)
      OP_AND:  alu_f = a_op & b_op;
      OP_OR:   alu_f = a_op | b_op;
      OP_XOR:  alu_f = a_op ^ b_op;
      OP_NOR:  alu_f = ~(a_op | b_op);
      OP_ADD: begin
        sum             = {1'b0, a_op} + {1'b0, b_op};
        {alu_cf, alu_f} = sum;
        alu_of          = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (alu_f[WIDTH-1] != a_op[WIDTH-1]);
      end
      OP_SUB: begin
        alu_f  = a_op - b_op;
        alu_cf = a_op < b_op;
        alu_of = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (alu_f[WIDTH-1] != a_op[WIDTH-1]);
      end
      OP_SLT:  alu_f = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: alu_f = {{(WIDTH-1){1'b0}}, (a_op < b_op)};
      OP_SLL:  alu_f = b_op << sh;
      OP_SRL:  alu_f = b_op >> sh;
      OP_SRA:  alu_f = $unsigned($signed(b_op) >>> sh);
      OP_INC: begin
        sum             = {1'b0, a_op} + (WIDTH+1)'(1);
        {alu_cf, alu_f} = sum;
        alu_of          = (a_op == {1'b0, {(WIDTH-1){1'b1}}});
      end
      default: alu_f = a_op;
    endcase
  end

  // Writeback stage register; result and flags hold while idle.
  always_ff @(posedge clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      ZF        <= 1'b0;
      OF        <= 1'b0;
      CF        <= 1'b0;
      NF        <= 1'b0;
      w_rd      <= '0;
      w_wr_en   <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      result    <= alu_f;
      ZF        <= (alu_f == '0);
      OF        <= alu_of;
      CF        <= alu_cf;
      NF        <= alu_f[WIDTH-1];
      w_rd      <= rd;
      w_wr_en   <= wr_en;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Register array: cleared on reset, written from the writeback stage.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (w_commit) begin
      regs[w_rd] <= result;
    end
  end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Testbench for alu_regfile_pipe: directed vectors, scoreboard queues and monitors.
module tb_alu_regfile_pipe;

  localparam logic [3:0] OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_XOR = 4'd2,  OP_NOR  = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_SUB = 4'd5,  OP_SLT = 4'd6,  OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_INC  = 4'd11;
  localparam logic [3:0] OP_PASS = 4'd15;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {ZF, OF, CF, NF}
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic        mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q32[$];
  exp_t        q16[$];

  // 32-bit instance signals
  logic        in_valid, wr_en, out_valid, zf, of, cf, nf;
  logic [3:0]  alu_op;
  logic [4:0]  ra, rb, rd, dbg_addr;
  logic [31:0] result, dbg_data;

  // 16-bit instance signals
  logic        s_in_valid, s_wr_en, s_out_valid, s_zf, s_of, s_cf, s_nf;
  logic [3:0]  s_alu_op;
  logic [2:0]  s_ra, s_rb, s_rd, s_dbg_addr;
  logic [15:0] s_result, s_dbg_data;

  always #5 clk = ~clk;

  alu_regfile_pipe #(.WIDTH(32), .ADDR_W(5)) u32 (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .alu_op(alu_op),
    .ra(ra), .rb(rb), .rd(rd), .wr_en(wr_en), .out_valid(out_valid),
    .result(result), .ZF(zf), .OF(of), .CF(cf), .NF(nf),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu_regfile_pipe #(.WIDTH(16), .ADDR_W(3)) u16 (
    .clk(clk), .Reset(Reset), .in_valid(s_in_valid), .alu_op(s_alu_op),
    .ra(s_ra), .rb(s_rb), .rd(s_rd), .wr_en(s_wr_en), .out_valid(s_out_valid),
    .result(s_result), .ZF(s_zf), .OF(s_of), .CF(s_cf), .NF(s_nf),
    .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input int a, input int b, input int d,
                       input logic we, input logic [31:0] r, input logic [3:0] f);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; ra = 5'(a); rb = 5'(b); rd = 5'(d); wr_en = we;
    e.res = r; e.flg = f;
    q32.push_back(e);
  endtask

  task automatic issue16(input logic [3:0] op, input int a, input int b, input int d,
                         input logic we, input logic [15:0] r, input logic [3:0] f);
    exp_t e;
    @(negedge clk);
    s_in_valid = 1'b1; s_alu_op = op; s_ra = 3'(a); s_rb = 3'(b); s_rd = 3'(d); s_wr_en = we;
    e.res = {16'h0, r}; e.flg = f;
    q16.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      s_in_valid = 1'b0;
    end
  endtask

  task automatic dbg_chk(input int addr, input logic [31:0] exp);
    dbg_addr = 5'(addr);
    #1;
    chk($sformatf("dbg_r%0d", addr), dbg_data, exp);
  endtask

  // Monitor for the 32-bit instance: pop and compare whenever a result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && out_valid) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL out32_unexpected actual=%h expected=none", result);
      end else begin
        e = q32.pop_front();
        chk("res32", result, e.res);
        chk("flags32", {28'h0, zf, of, cf, nf}, {28'h0, e.flg});
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && s_out_valid) begin
      if (q16.size() == 0) begin
        checks++; failures++;
        $display("FAIL out16_unexpected actual=%h expected=none", s_result);
      end else begin
        e = q16.pop_front();
        chk("res16", {16'h0, s_result}, e.res);
        chk("flags16", {28'h0, s_zf, s_of, s_cf, s_nf}, {28'h0, e.flg});
      end
    end
  end

  initial begin
    Reset = 1'b1;
    in_valid = 1'b0; alu_op = '0; ra = '0; rb = '0; rd = '0; wr_en = 1'b0; dbg_addr = '0;
    s_in_valid = 1'b0; s_alu_op = '0; s_ra = '0; s_rb = '0; s_rd = '0; s_wr_en = 1'b0;
    s_dbg_addr = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {28'h0, zf, of, cf, nf}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk("rst_dbg", dbg_data, 32'h0);
    end
    mon_en = 1'b1;

    // Back-to-back dependency through the bypass
    issue(OP_INC, 0, 0, 1, 1'b1, 32'h1, 4'b0000);
    issue(OP_ADD, 1, 1, 2, 1'b1, 32'h2, 4'b0000);
    idle(2);
    dbg_chk(2, 32'h2);

    // Build operands, then overflow / carry cases
    issue(OP_NOR, 0, 0, 5, 1'b1, 32'hFFFF_FFFF, 4'b0001);
    issue(OP_SRL, 1, 5, 3, 1'b1, 32'h7FFF_FFFF, 4'b0000);
    issue(OP_INC, 0, 0, 4, 1'b1, 32'h1, 4'b0000);
    issue(OP_ADD, 3, 4, 6, 1'b1, 32'h8000_0000, 4'b0101);
    issue(OP_ADD, 5, 4, 0, 1'b0, 32'h0, 4'b1010);
    issue(OP_SUB, 0, 4, 0, 1'b0, 32'hFFFF_FFFF, 4'b0011);
    issue(OP_SLT, 5, 4, 0, 1'b0, 32'h1, 4'b0000);
    issue(OP_SLTU, 5, 4, 0, 1'b0, 32'h0, 4'b1000);
    issue(OP_ADD, 2, 2, 9, 1'b1, 32'h4, 4'b0000);
    issue(OP_SRA, 9, 6, 8, 1'b1, 32'hF800_0000, 4'b0001);
    issue(OP_XOR, 5, 4, 0, 1'b0, 32'hFFFF_FFFE, 4'b0001);
    issue(OP_AND, 5, 3, 0, 1'b0, 32'h7FFF_FFFF, 4'b0000);
    issue(OP_OR, 3, 6, 0, 1'b0, 32'hFFFF_FFFF, 4'b0001);
    issue(OP_PASS, 6, 0, 0, 1'b0, 32'h8000_0000, 4'b0001);
    issue(OP_SLL, 4, 6, 0, 1'b0, 32'h0, 4'b1000);

    // Register 0 write is dropped and never bypassed
    issue(OP_INC, 0, 0, 0, 1'b1, 32'h1, 4'b0000);
    issue(OP_ADD, 0, 0, 10, 1'b1, 32'h0, 4'b1000);
    issue(4'd12, 6, 0, 0, 1'b0, 32'h8000_0000, 4'b0001);
    idle(2);
    chk("hold_out_valid", {31'h0, out_valid}, 32'h0);
    chk("hold_result", result, 32'h8000_0000);
    chk("hold_nf", {31'h0, nf}, 32'h1);
    dbg_chk(0, 32'h0);
    dbg_chk(8, 32'hF800_0000);
    dbg_chk(3, 32'h7FFF_FFFF);

    // Reset in the writeback cycle discards the write to r7
    issue(OP_INC, 0, 0, 7, 1'b1, 32'h1, 4'b0000);
    @(negedge clk);
    in_valid = 1'b0;
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("rst2_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst2_result", result, 32'h0);
    idle(1);
    dbg_chk(7, 32'h0);
    dbg_chk(3, 32'h0);

    // 16-bit instance: shift amount uses only the low 4 bits
    issue16(OP_INC, 0, 0, 1, 1'b1, 16'h0001, 4'b0000);
    issue16(OP_ADD, 1, 1, 2, 1'b1, 16'h0002, 4'b0000);
    issue16(OP_ADD, 2, 2, 3, 1'b1, 16'h0004, 4'b0000);
    issue16(OP_SLL, 3, 1, 4, 1'b1, 16'h0010, 4'b0000);
    issue16(OP_ADD, 4, 1, 5, 1'b1, 16'h0011, 4'b0000);
    issue16(OP_SLL, 5, 1, 6, 1'b1, 16'h0002, 4'b0000);
    issue16(OP_NOR, 0, 0, 7, 1'b1, 16'hFFFF, 4'b0001);
    issue16(OP_INC, 7, 0, 0, 1'b0, 16'h0000, 4'b1010);
    issue16(OP_ADD, 7, 7, 0, 1'b0, 16'hFFFE, 4'b0011);
    idle(3);

    chk("drain32", 32'(q32.size()), 32'h0);
    chk("drain16", 32'(q16.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_regfile_pipe.md
Name: alu_regfile_pipe

Overview:
- Parametrised successor of the 32x32 register file + 8-op ALU datapath.
- Issues one register-to-register ALU instruction per cycle.
- Two-stage pipeline: read/execute, then writeback, with bypass from writeback to read.
- Register 0 is hardwired to zero. Adds carry and sign flags, an extended op set and a debug read port.

Parameters:
- WIDTH, 32, datapath and register width (>=8, power of 2)
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
- SH_W, $clog2(WIDTH), shift-amount width (derived, not overridable)

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high
- in_valid  in  1  instruction present this cycle
- alu_op  in  4  operation code
- ra  in  ADDR_W  operand A register address
- rb  in  ADDR_W  operand B register address
- rd  in  ADDR_W  destination register address
- wr_en  in  1  write result to rd at writeback
- out_valid  out  1  result/flags valid (writeback stage occupied)
- result  out  WIDTH  registered ALU result
- ZF  out  1  result == 0
- OF  out  1  signed overflow
- CF  out  1  carry out (ADD/INC), borrow (SUB)
- NF  out  1  result[WIDTH-1]
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  WIDTH  combinational read of register dbg_addr, bypass NOT applied

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - all DEPTH registers <= 0
  - out_valid, result, ZF, OF, CF, NF <= 0
  - any in-flight writeback is discarded (no register write on a Reset edge)
- Stage E, issue cycle N:
  - A = read(ra), B = read(rb), computed combinationally
  - read(0) = 0 always
  - bypass: if the W stage is valid, has wr_en, rd_w != 0 and rd_w == ra (or rb), then the operand takes W.result instead of the array value
  - ALU computes F and flags; at edge N, if in_valid: W stage <= {valid=1, result=F, flags, rd, wr_en}, else W.valid <= 0
- Stage W, cycle N+1:
  - out_valid=1; result/flags are stable for the whole cycle
  - at edge N+1, if wr_en && rd != 0: REG[rd] <= result
  - writes to register 0 are silently dropped
- Latency: result is visible 1 cycle after issue. Throughput: 1 instruction per cycle; no stalls.
- Back-to-back dependency (issue at N writes r5, issue at N+1 reads r5) gets the new value via bypass.
- Two-apart dependency reads the written array value.
- When out_valid=0, result and flags hold their last values.
- Op codes, operating on WIDTH bits (OF=0, CF=0 unless stated):
  - 0 AND: A&B
  - 1 OR: A|B
  - 2 XOR: A^B
  - 3 NOR: ~(A|B)
  - 4 ADD: {CF,F}=A+B; OF=(A[msb]==B[msb])&&(F[msb]!=A[msb])
  - 5 SUB: F=A-B; CF=(A<B unsigned); OF=(A[msb]!=B[msb])&&(F[msb]!=A[msb])
  - 6 SLT: F=1 if signed A<B, else 0
  - 7 SLTU: F=1 if unsigned A<B, else 0
  - 8 SLL: F=B<<A[SH_W-1:0]
  - 9 SRL: F=B>>A[SH_W-1:0], logical
  - 10 SRA: arithmetic right shift of B by A[SH_W-1:0]
  - 11 INC: {CF,F}=A+1; OF=(A==0111..1)
  - 12-15: F=A
- ZF=(F==0) and NF=F[msb] for every op.
- Shift amounts >= WIDTH are impossible by construction, because only SH_W bits are used.

Test Plan:
- Reset high for 2 cycles, then low -> out_valid=0, result=0, all flags 0; dbg_data=0 for every dbg_addr 0..31.
- Write: (ra=0, rb=0, op=INC, rd=1, wr_en) then (ra=1, rb=1, op=ADD, rd=2, wr_en) back-to-back -> results 1, then 2 via bypass; dbg_addr=2 reads 2 afterwards.
- Overflow/carry: r3=0x7FFFFFFF, r4=1, ADD -> result 0x80000000, OF=1, CF=0, NF=1. Then 0xFFFFFFFF + 1 -> result 0, ZF=1, CF=1, OF=0.
- SUB 0 - 1 -> 0xFFFFFFFF, CF=1, OF=0. SLT with A=-1, B=1 -> 1; SLTU with the same operands -> 0. SRA of 0x80000000 by 4 -> 0xF8000000.
- Write to r0 with op=INC and wr_en -> out_valid=1 with result=1, but a subsequent read of r0 = 0 and no bypass from rd=0.
- Reset asserted in the cycle after issuing a write to r7 -> r7 stays 0 and out_valid=0. WIDTH=16, ADDR_W=3 instance: SLL by A=17 shifts by 1.
